pipe_sequencer: RTL and testbench

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_sequencer_if.sv | 54 +++++
 rtl/hazard_detect.sv | 26 ++
 rtl/pipe_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pipe_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and default widths for the pipeline sequencer:
//               FSM state encoding, register-address width, stall-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Default register-address width (32 architectural registers)
  localparam int REG_AW = 5;

  // Default stalled-cycle counter width
  localparam int CNT_W  = 16;

  // Sequencer FSM: normal flow, or frozen waiting on data memory
  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_sequencer_if.sv
// ============================================================================
// Module      : pipe_sequencer_if
// Description : Bundle of pipeline status inputs and control outputs of the
//               sequencer. master = pipeline datapath side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_sequencer_if #(
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = pipe_pkg::CNT_W
);

  // Pipeline status towards the sequencer
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              ex_memread_i;
  logic [REG_AW-1:0] ex_rd_i;
  logic              branch_taken_i;
  logic              mem_access_i;
  logic              dmem_ack_i;
  logic              cnt_clr_i;

  // Sequencer controls towards the pipeline
  logic              dmem_req_o;
  logic              pc_en_o;
  logic              ifid_en_o;
  logic              idex_en_o;
  logic              exmem_en_o;
  logic              memwb_en_o;
  logic              ifid_flush_o;
  logic              idex_flush_o;
  logic              memwb_flush_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              err_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, ex_memread_i, ex_rd_i,
           branch_taken_i, mem_access_i, dmem_ack_i, cnt_clr_i,
    input  dmem_req_o, pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
           ifid_flush_o, idex_flush_o, memwb_flush_o, stall_cnt_o, err_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, ex_memread_i, ex_rd_i,
           branch_taken_i, mem_access_i, dmem_ack_i, cnt_clr_i,
    output dmem_req_o, pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
           ifid_flush_o, idex_flush_o, memwb_flush_o, stall_cnt_o, err_o
  );

endinterface : pipe_sequencer_if

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Purely combinational load-use hazard detector. Flags when the
//               EX-stage load writes a non-zero register read by the ID stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect #(
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  wire logic              i_id_valid,
  input  wire logic [REG_AW-1:0] i_id_rs1,
  input  wire logic [REG_AW-1:0] i_id_rs2,
  input  wire logic              i_ex_memread,
  input  wire logic [REG_AW-1:0] i_ex_rd,
  output logic                   o_load_use
);

  // Register 0 is hard-wired, so a load targeting it never creates a hazard
  assign o_load_use = i_id_valid & i_ex_memread & (i_ex_rd != '0) &
                      ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));

endmodule : hazard_detect

`default_nettype wire

// File: rtl/pipe_sequencer.sv
// ============================================================================
// Module      : pipe_sequencer
// Description : Pipeline stall/flush sequencer. Freezes the pipeline while data
//               memory is busy, inserts bubbles for load-use hazards and taken
//               branches, and counts stalled cycles.
//               Optional macro PIPE_SEQ_TIMEOUT_EN adds a memory-wait watchdog
//               (MEM_TIMEOUT cycles) with a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_sequencer #(
  parameter int REG_AW      = pipe_pkg::REG_AW,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = pipe_pkg::CNT_W
) (
  input  wire logic       clk_i,
  input  wire logic       rst_n_i,
  pipe_sequencer_if.slave bus
);

  import pipe_pkg::*;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_load_use;
  logic             w_timeout;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_dmem_req;
  logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic w_ifid_flush, w_idex_flush, w_memwb_flush;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .i_id_valid   (bus.id_valid_i),
    .i_id_rs1     (bus.id_rs1_i),
    .i_id_rs2     (bus.id_rs2_i),
    .i_ex_memread (bus.ex_memread_i),
    .i_ex_rd      (bus.ex_rd_i),
    .o_load_use   (w_load_use)
  );

`ifdef PIPE_SEQ_TIMEOUT_EN
  localparam int WD_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;

  // Fires on the wait cycle after MEM_TIMEOUT ack-less MEM_WAIT cycles
  assign w_timeout = (r_state == ST_MEM_WAIT) && !bus.dmem_ack_i &&
                     (r_wd_cnt == WD_W'(MEM_TIMEOUT));

  // Watchdog: counts ack-less MEM_WAIT cycles, restarts on any exit
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wd_cnt <= '0;
    end else if ((r_state == ST_MEM_WAIT) && !bus.dmem_ack_i && !w_timeout) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // Sticky timeout flag, only cleared by reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;
`else
  logic w_unused_cfg;

  // Without the watchdog the wait is unbounded and the error flag is tied off
  assign w_timeout    = 1'b0;
  assign bus.err_o    = 1'b0;
  assign w_unused_cfg = (MEM_TIMEOUT != 0);
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: enter wait on an un-acked access, leave on ack or watchdog
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (bus.mem_access_i && !bus.dmem_ack_i) begin
          w_state_nxt = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ack_i || w_timeout) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs: memory stall > branch flush > load-use bubble
  always_comb begin
    w_dmem_req    = 1'b0;
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_idex_en     = 1'b1;
    w_exmem_en    = 1'b1;
    w_memwb_en    = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_memwb_flush = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_dmem_req = bus.mem_access_i;
        if (bus.mem_access_i && !bus.dmem_ack_i) begin
          w_pc_en    = 1'b0;
          w_ifid_en  = 1'b0;
          w_idex_en  = 1'b0;
          w_exmem_en = 1'b0;
          w_memwb_en = 1'b0;
        end else if (bus.branch_taken_i) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
        end else if (w_load_use) begin
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ack_i) begin
          // Release cycle: the frozen EX stage re-presents its branch outcome
          w_dmem_req = 1'b1;
          if (bus.branch_taken_i) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end
        end else if (w_timeout) begin
          // Abandon the access: advance and bubble the result that never came
          w_memwb_flush = 1'b1;
        end else begin
          w_dmem_req = 1'b1;
          w_pc_en    = 1'b0;
          w_ifid_en  = 1'b0;
          w_idex_en  = 1'b0;
          w_exmem_en = 1'b0;
          w_memwb_en = 1'b0;
        end
      end
      default: begin
        w_dmem_req = 1'b0;
      end
    endcase
  end

  // Stalled-cycle counter: counts frozen-PC cycles, saturates, clear wins
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
    end else if (bus.cnt_clr_i) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_en && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.dmem_req_o    = w_dmem_req;
  assign bus.pc_en_o       = w_pc_en;
  assign bus.ifid_en_o     = w_ifid_en;
  assign bus.idex_en_o     = w_idex_en;
  assign bus.exmem_en_o    = w_exmem_en;
  assign bus.memwb_en_o    = w_memwb_en;
  assign bus.ifid_flush_o  = w_ifid_flush;
  assign bus.idex_flush_o  = w_idex_flush;
  assign bus.memwb_flush_o = w_memwb_flush;
  assign bus.stall_cnt_o   = r_stall_cnt;

endmodule : pipe_sequencer

`default_nettype wire

// File: tb/tb_pipe_sequencer.sv
// ============================================================================
// Module      : tb_pipe_sequencer
// Description : Scoreboard bench for pipe_sequencer. The driver applies one
//               directed vector per cycle and queues the expected outputs; a
//               monitor on the falling edge pops and compares.
//               Expectations for the watchdog follow PIPE_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_sequencer;

  // Expected control bits: {err, req, pc, ifid, idex, exmem, memwb, ifl, idfl, mwfl}
  localparam logic [9:0] E_RUN   = 10'b0_0_11111_000;
  localparam logic [9:0] E_REQ   = 10'b0_1_11111_000;
  localparam logic [9:0] E_STALL = 10'b0_1_00000_000;
  localparam logic [9:0] E_LU    = 10'b0_0_00111_010;
  localparam logic [9:0] E_BR    = 10'b0_0_11111_110;
  localparam logic [9:0] E_TO    = 10'b0_0_11111_001;
  localparam logic [9:0] E_ERR   = 10'b1_0_00000_000;

  logic clk;
  logic rst_n;

  logic [25:0] exp_q[$];
  string       nm_q[$];
  int          n_checks;
  int          n_err;
  logic        drv_done;

  pipe_sequencer_if #(.REG_AW(5), .CNT_W(16)) bus ();

  pipe_sequencer #(
    .REG_AW      (5),
    .MEM_TIMEOUT (4),
    .CNT_W       (16)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: apply inputs, queue the expectation, advance past the edge
  task automatic cyc(input string nm, input logic v, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic mr, input logic [4:0] rd,
                     input logic br, input logic ma, input logic ack,
                     input logic clr, input logic [9:0] ec, input int ecnt);
    bus.id_valid_i     = v;
    bus.id_rs1_i       = rs1;
    bus.id_rs2_i       = rs2;
    bus.ex_memread_i   = mr;
    bus.ex_rd_i        = rd;
    bus.branch_taken_i = br;
    bus.mem_access_i   = ma;
    bus.dmem_ack_i     = ack;
    bus.cnt_clr_i      = clr;
    exp_q.push_back({ec, 16'(ecnt)});
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input logic [9:0] ec, input int ecnt);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, ec, ecnt);
  endtask

  task automatic mem(input string nm, input logic ack, input logic [9:0] ec, input int ecnt);
    cyc(nm, 0, 0, 0, 0, 0, 0, 1, ack, 0, ec, ecnt);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    logic [25:0] act;
    logic [25:0] exp_v;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = nm_q.pop_front();
        act   = {bus.err_o, bus.dmem_req_o, bus.pc_en_o, bus.ifid_en_o,
                 bus.idex_en_o, bus.exmem_en_o, bus.memwb_en_o, bus.ifid_flush_o,
                 bus.idex_flush_o, bus.memwb_flush_o, bus.stall_cnt_o};
        n_checks++;
        if (act !== exp_v) begin
          n_err++;
          $display("FAIL %s: ctl got %b want %b, stall_cnt got %0d want %0d",
                   nm, act[25:16], exp_v[25:16], act[15:0], exp_v[15:0]);
        end
      end
    end
  end

  // Driver: directed vectors with hand-computed expectations
  initial begin
    n_checks = 0;
    n_err    = 0;
    drv_done = 1'b0;
    rst_n    = 1'b0;
    bus.id_valid_i = 0; bus.id_rs1_i = 0; bus.id_rs2_i = 0; bus.ex_memread_i = 0;
    bus.ex_rd_i = 0; bus.branch_taken_i = 0; bus.mem_access_i = 0;
    bus.dmem_ack_i = 0; bus.cnt_clr_i = 0;
    @(posedge clk);
    #1;
    idle("reset", E_RUN, 0);
    rst_n = 1'b1;
    idle("idle", E_RUN, 0);
    //   name           v rs1 rs2 mr rd br ma ak clr  exp     cnt
    cyc("lu_rs2",       1, 3,  5, 1, 5, 0, 0, 0, 0, E_LU,   0);
    idle("lu_after",                                 E_RUN,  1);
    cyc("lu_rd0",       1, 3,  0, 1, 0, 0, 0, 0, 0, E_RUN,  1);
    cyc("lu_rs1",       1, 7,  2, 1, 7, 0, 0, 0, 0, E_LU,   1);
    cyc("lu_novalid",   0, 7,  2, 1, 7, 0, 0, 0, 0, E_RUN,  2);
    cyc("lu_noload",    1, 7,  2, 0, 7, 0, 0, 0, 0, E_RUN,  2);
    cyc("br_and_lu",    1, 3,  5, 1, 5, 1, 0, 0, 0, E_BR,   2);
    cyc("branch",       0, 0,  0, 0, 0, 1, 0, 0, 0, E_BR,   2);
    mem("mem_zero_wait", 1,                          E_REQ,  2);
    mem("mem_enter",     0,                          E_STALL, 2);
    cyc("wait_br_lu",   1, 3,  5, 1, 5, 1, 1, 0, 0, E_STALL, 3);
    mem("wait_3",        0,                          E_STALL, 4);
    mem("wait_ack",      1,                          E_REQ,  5);
    idle("after_release",                            E_RUN,  5);
    cyc("mem_over_lu",  1, 3,  5, 1, 5, 0, 1, 0, 0, E_STALL, 5);
    mem("ack2",          1,                          E_REQ,  6);
    cyc("clr",          0, 0,  0, 0, 0, 0, 0, 0, 1, E_RUN,  6);
    cyc("clr_vs_inc",   1, 3,  5, 1, 5, 0, 0, 0, 1, E_LU,   0);
    idle("after_clr",                                E_RUN,  0);
    mem("to_enter",      0,                          E_STALL, 0);
    mem("to_wait1",      0,                          E_STALL, 1);
    mem("to_wait2",      0,                          E_STALL, 2);
    mem("to_wait3",      0,                          E_STALL, 3);
    mem("to_wait4",      0,                          E_STALL, 4);
`ifdef PIPE_SEQ_TIMEOUT_EN
    mem("to_fire",       0,                          E_TO,   5);
    idle("err_sticky",                               E_RUN | E_ERR, 5);
    mem("err_run_req",   1,                          E_REQ | E_ERR, 5);
    mem("rw_enter",      0,                          E_STALL | E_ERR, 5);
    mem("rw_wait",       0,                          E_STALL | E_ERR, 6);
`else
    mem("no_to_wait5",   0,                          E_STALL, 5);
    mem("no_to_wait6",   0,                          E_STALL, 6);
    mem("no_to_ack",     1,                          E_REQ,  7);
    mem("rw_enter",      0,                          E_STALL, 7);
    mem("rw_wait",       0,                          E_STALL, 8);
`endif
    // Asynchronous reset pulse between clock edges, mid-wait
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    idle("rst_abandon",                              E_RUN,  0);
    mem("rst_run_zw",    1,                          E_REQ,  0);
    idle("rst_idle",                                 E_RUN,  0);
    drv_done = 1'b1;
  end

  // End of test: drain the scoreboard within a bounded number of cycles
  initial begin
    wait (drv_done === 1'b1);
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: pending got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #100000;
    $display("FAIL watchdog: sim time got %0t want driver finished", $time);
    $fatal(1, "simulation time limit");
  end

endmodule : tb_pipe_sequencer

`default_nettype wire
